// File: rtl/hd_receiver.sv
// hd_receiver: consumer side of the valid/ready beat link.
// Incoming beats pass through a one-entry skid register, so ready_output can come
// straight from a flop. Beats are then packed PACK at a time, or fewer when last
// is set, into one wide word offered on a downstream valid/ready port.
// word_dest is also the assembly register. The assembler stalls while a finished
// word is held, so a separate staging buffer would never be filled ahead of the
// handoff.
module hd_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int PACK       = 4,
  localparam int CW        = $clog2(PACK + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_src,
  input  logic                       valid,
  input  logic                       last,
  output logic                       ready_output,
  output logic [PACK*DATA_WIDTH-1:0] word_dest,
  output logic [CW-1:0]              word_beats,
  output logic                       word_valid,
  input  logic                       word_ready
);

  // Skid entry (stage p0). Its data fields are never reset; skid_vld_p0 alone says
  // whether they mean anything.
  logic                  skid_vld_p0;
  logic [DATA_WIDTH-1:0] skid_data_p0;
  logic                  skid_last_p0;

  // Lane counter of the word under assembly.
  logic [CW-1:0]         cnt;

  // Routing decisions for the current cycle.
  logic                  accept;
  logic                  can_take;
  logic                  asm_vld;
  logic [DATA_WIDTH-1:0] asm_data;
  logic                  asm_last;
  logic                  skid_load;
  logic                  skid_vld_nxt;
  logic                  complete;
  logic [PACK*DATA_WIDTH-1:0] word_nxt;

  // Route the beat: a parked skid beat drains before any newly accepted beat.
  always_comb begin
    accept       = valid && ready_output;
    can_take     = !word_valid || word_ready;
    asm_vld      = 1'b0;
    asm_data     = data_src;
    asm_last     = last;
    skid_load    = 1'b0;
    skid_vld_nxt = skid_vld_p0;
    if (skid_vld_p0) begin
      if (can_take) begin
        asm_vld      = 1'b1;
        asm_data     = skid_data_p0;
        asm_last     = skid_last_p0;
        skid_load    = accept;
        skid_vld_nxt = accept;
      end
    end else if (accept) begin
      if (can_take) begin
        asm_vld = 1'b1;
      end else begin
        skid_load    = 1'b1;
        skid_vld_nxt = 1'b1;
      end
    end
  end

  // Lane update: write lane cnt. The first beat of a word also clears every other lane.
  always_comb begin
    word_nxt = word_dest;
    if (asm_vld) begin
      for (int k = 0; k < PACK; k++) begin
        if (cnt == CW'(k)) begin
          word_nxt[k*DATA_WIDTH +: DATA_WIDTH] = asm_data;
        end else if (cnt == '0) begin
          word_nxt[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
    complete = asm_vld && (asm_last || (cnt == CW'(PACK - 1)));
  end

  // Skid payload (stage p0 boundary): loaded only when the entry is being filled.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data_p0 <= data_src;
      skid_last_p0 <= last;
    end
  end

  // Control and output word: skid occupancy, registered ready, lane count, word handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_p0  <= 1'b0;
      ready_output <= 1'b0;
      cnt          <= '0;
      word_valid   <= 1'b0;
      word_beats   <= '0;
      word_dest    <= '0;
    end else begin
      skid_vld_p0  <= skid_vld_nxt;
      ready_output <= !skid_vld_nxt;
      if (asm_vld) begin
        word_dest <= word_nxt;
      end
      if (complete) begin
        word_valid <= 1'b1;
        word_beats <= cnt + 1'b1;
        cnt        <= '0;
      end else begin
        if (asm_vld) begin
          cnt <= cnt + 1'b1;
        end
        if (word_valid && word_ready) begin
          word_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hd_receiver.sv
// tb_hd_receiver: directed scenarios plus a long random run. A beat-list reference
// model builds expected words from accepted beats, and a scoreboard compares them
// with the words handed downstream.
module tb_hd_receiver;

  localparam int DW   = 32;
  localparam int PACK = 4;
  localparam int WW   = DW * PACK;
  localparam int CW   = $clog2(PACK + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_src;
  logic          valid;
  logic          last;
  logic          ready_output;
  logic [WW-1:0] word_dest;
  logic [CW-1:0] word_beats;
  logic          word_valid;
  logic          word_ready;

  int checks   = 0;
  int failures = 0;

  hd_receiver #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_src     (data_src),
    .valid        (valid),
    .last         (last),
    .ready_output (ready_output),
    .word_dest    (word_dest),
    .word_beats   (word_beats),
    .word_valid   (word_valid),
    .word_ready   (word_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a list of accepted beats grouped into expected words.
  typedef struct {
    logic [WW-1:0] dest;
    int            beats;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] cur[PACK];
  int            cur_n      = 0;
  int            beats_acc  = 0;
  bit            held       = 0;
  logic [WW-1:0] held_dest;
  logic [CW-1:0] held_beats;

  task automatic model_beat(input logic [DW-1:0] d, input logic l);
    word_t w;
    cur[cur_n] = d;
    cur_n++;
    beats_acc++;
    if (cur_n == PACK || l) begin
      w.dest = '0;
      for (int k = 0; k < cur_n; k++) w.dest[k*DW +: DW] = cur[k];
      w.beats = cur_n;
      exp_q.push_back(w);
      cur_n = 0;
    end
  endtask

  // Monitor at the falling edge: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cur_n = 0;
      held  = 0;
    end else begin
      if (held) begin
        chk("hold_dest", word_dest, held_dest);
        chk("hold_beats", WW'(word_beats), WW'(held_beats));
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", WW'(1), WW'(0));
        end else begin
          chk("sb_dest", word_dest, exp_q[0].dest);
          chk("sb_beats", WW'(word_beats), WW'(exp_q[0].beats));
          void'(exp_q.pop_front());
        end
      end
      if (valid && ready_output) model_beat(data_src, last);
      held       = word_valid && !word_ready;
      held_dest  = word_dest;
      held_beats = word_beats;
    end
  end

  // One cycle of drive, 1 time unit after the rising edge. ready_output must not
  // react to a change of word_ready inside the cycle.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic wr);
    logic r0, wr0;
    @(posedge clk);
    #1;
    r0  = ready_output;
    wr0 = word_ready;
    valid      = v;
    data_src   = d;
    last       = l;
    word_ready = wr;
    #1;
    if (wr != wr0) chk("rdy_registered", WW'(ready_output), WW'(r0));
  endtask

  // Present a beat and hold it until it will be taken at the next rising edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic wr);
    int n;
    step(1'b1, d, l, wr);
    n = 0;
    while (!ready_output && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!ready_output) chk("send_timeout", WW'(0), WW'(1));
  endtask

  initial begin
    rst        = 1'b1;
    valid      = 1'b0;
    data_src   = '0;
    last       = 1'b0;
    word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", WW'(ready_output), WW'(0));
    chk("rst_wvalid", WW'(word_valid), WW'(0));
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("rel_ready_low", WW'(ready_output), WW'(0));
    @(posedge clk);
    #1;
    chk("rel_ready_up", WW'(ready_output), WW'(1));

    // Reset in the middle of a word
    send_beat(32'h1, 1'b0, 1'b1);
    send_beat(32'h2, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    valid = 1'b0;
    rst   = 1'b1;
    #1;
    chk("mid_rst_ready", WW'(ready_output), WW'(0));
    chk("mid_rst_wvalid", WW'(word_valid), WW'(0));
    chk("mid_rst_dest", word_dest, WW'(0));
    chk("mid_rst_beats", WW'(word_beats), WW'(0));
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready_up", WW'(ready_output), WW'(1));
    for (int i = 0; i < PACK; i++) send_beat(DW'(32'h50 + i), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_wvalid", WW'(word_valid), WW'(1));
    chk("t1_beats", WW'(word_beats), WW'(4));

    // Streaming
    send_beat(32'h11, 1'b0, 1'b1);
    send_beat(32'h22, 1'b0, 1'b1);
    send_beat(32'h33, 1'b0, 1'b1);
    send_beat(32'h44, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t2_wvalid", WW'(word_valid), WW'(1));
    chk("t2_dest", word_dest, 128'h00000044_00000033_00000022_00000011);
    chk("t2_beats", WW'(word_beats), WW'(4));

    // Early last
    send_beat(32'hA, 1'b0, 1'b1);
    send_beat(32'hB, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t3_dest", word_dest, 128'h00000000_00000000_0000000B_0000000A);
    chk("t3_beats", WW'(word_beats), WW'(2));

    // Downstream stall with continuous upstream valid
    for (int i = 1; i <= 5; i++) send_beat(DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b0, 1'b0);
    chk("t4_ready_low", WW'(ready_output), WW'(0));
    chk("t4_wvalid_held", WW'(word_valid), WW'(1));
    step(1'b1, 32'h6, 1'b0, 1'b0);
    chk("t4_ready_still_low", WW'(ready_output), WW'(0));
    send_beat(32'h6, 1'b0, 1'b1);
    send_beat(32'h7, 1'b0, 1'b1);
    send_beat(32'h8, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_dest", word_dest, 128'h00000008_00000007_00000006_00000005);
    chk("t4_beats", WW'(word_beats), WW'(4));

    // Handoff and completion in the same cycle: back-to-back words with no bubble
    send_beat(32'hC1, 1'b1, 1'b1);
    send_beat(32'hC2, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_v1", WW'(word_valid), WW'(1));
    send_beat(32'hC3, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_v2", WW'(word_valid), WW'(1));
    step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_v3", WW'(word_valid), WW'(1));
    chk("t6_dest", word_dest, WW'(32'hC3));
    step(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_drop", WW'(word_valid), WW'(0));

    // Random traffic
    begin
      int start;
      int cyc;
      start = beats_acc;
      cyc   = 0;
      while ((beats_acc - start) < 10000 && cyc < 60000) begin
        step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 2,
             $urandom_range(0, 9) < 7);
        cyc++;
      end
      chk("rand_beats_done", WW'((beats_acc - start) >= 10000), WW'(1));
    end
    repeat (10) step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_empty", WW'(exp_q.size()), WW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
